instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage of the MIPS monocycle datapath. It sits directly upstream of ControlUnit.
- Holds the PC and requests instructions from instruction memory over a ready handshake.
- Presents the fetched word and its OPCode/Funct fields to the control unit and datapath.
- Computes the next PC from the Branch/Jump decisions that ControlUnit produces and the ALU Zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width; fixed at 32 for MIPS

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
IMemReq  out  1  instruction memory request
IMemAddr  out  32  fetch address; equals PC
IMemReady  in  1  memory has IMemRData valid this cycle
IMemRData  in  32  instruction word from memory
Instr  out  32  registered instruction
OPCode  out  6  Instr[31:26], feeds ControlUnit
Funct  out  6  Instr[5:0], feeds ControlUnit
InstrValid  out  1  Instr is valid and stable
Advance  in  1  datapath finished the current instruction; commit next PC
Branch  in  1  from ControlUnit
Jump  in  1  from ControlUnit
Zero  in  1  ALU zero flag
PC  out  32  current PC
PCPlus4  out  32  PC + 4, combinational
StallCount  out  32  fetch stall cycles (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port reset. It is sampled only on the rising edge and dominates all other inputs.
- Reset values:
  - PC = RESET_PC, state = REQ.
  - Instr = 0, InstrValid = 0, StallCount = 0.
  - IMemReq is 0 in the reset cycle itself.
  - OPCode = 0 and Funct = 0, which is decoded as R_TYPE.
- FSM states: REQ, ISSUE.
- REQ:
  - IMemReq = 1, IMemAddr = PC, InstrValid = 0.
  - IMemReq is held high until IMemReady = 1.
  - On an edge with IMemReady = 1: Instr <= IMemRData, go to ISSUE.
  - IMemRData is ignored while IMemReady = 0.
- ISSUE:
  - IMemReq = 0, InstrValid = 1. Instr, OPCode and Funct are held stable.
  - Advance = 0: stay in ISSUE.
  - Advance = 1: PC <= NextPC, go to REQ.
  - Advance is ignored in REQ.
- Latency:
  - Advance edge to the new IMemReq: 1 cycle.
  - IMemReady edge to InstrValid: 1 cycle.
  - Minimum 2 cycles per instruction.
- NextPC (combinational, 32-bit modulo arithmetic), in priority order:
  - Jump = 1: {PCPlus4[31:28], Instr[25:0], 2'b00}. Jump wins even when Branch = 1, because ControlUnit asserts both for J.
  - Branch & Zero: PCPlus4 + ({{14{Instr[15]}}, Instr[15:0], 2'b00}).
  - Otherwise: PCPlus4.
- Wrap-around: PC 32'hFFFF_FFFC with no branch or jump gives NextPC 32'h0000_0000. Branch targets also wrap silently. No fault is raised.
- Reset mid-operation:
  - Reset in REQ abandons the outstanding request; an IMemReady arriving in that cycle is ignored.
  - Reset in ISSUE discards Instr, even if Advance = 1 in the same cycle.
- OPCode and Funct are driven from the registered Instr, so ControlUnit inputs change only on a clk edge.

Optional Feature:
Macro: IF_STALL_COUNT_EN
- Defined:
  - StallCount is a 32-bit register that increments on every edge where state = REQ and IMemReady = 0.
  - It wraps from 32'hFFFF_FFFF to 0 and clears on reset.
- Undefined: StallCount is tied to 0 and no counter logic is built. The port remains so the interface is identical.

Test Plan:
- Reset then IMemReady = 1 held, IMemRData = 32'h2008_0005 (ADDI) → IMemAddr = 0x0, InstrValid = 1 one cycle later, OPCode = 6'h08, Funct = 6'h05; PC = 0x4 after the Advance pulse.
- Sequential fetch: three Advance pulses, no Branch/Jump → IMemAddr sequence 0x0, 0x4, 0x8, 0xC.
- BEQ at PC 0x10, Instr[15:0] = 16'hFFFE:
  - Branch = 1, Zero = 1, Advance → PC = 0x0C.
  - Same instruction with Zero = 0 → PC = 0x14.
- J at PC 0x1000_0020, Instr = 32'h0800_0040, Branch = Jump = 1 → PC = 0x1000_0100, not the branch target.
- Memory stall: IMemReady = 0 for 5 cycles then 1 → IMemReq and IMemAddr stable for 6 cycles. StallCount = 5 with IF_STALL_COUNT_EN; StallCount = 0 without it.
- Reset asserted in ISSUE with Advance = 1, and again in REQ with IMemReady = 1 → PC = RESET_PC, InstrValid = 0, Instr = 0, no state advance.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage of the MIPS monocycle datapath: PC, instruction-memory ready handshake, next-PC selection.
// Optional fetch stall counter is built when IF_STALL_COUNT_EN is defined.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemReady,
    input  logic [31:0]       IMemRData,
    output logic [31:0]       Instr,
    output logic [5:0]        OPCode,
    output logic [5:0]        Funct,
    output logic              InstrValid,
    input  logic              Advance,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Zero,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic [31:0]       StallCount
);

    // state   | meaning
    // S_REQ   | request outstanding at PC, waiting for IMemReady
    // S_ISSUE | Instr valid and held, waiting for Advance to commit NextPC
    typedef enum logic {
        S_REQ   = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_offset;

    assign PCPlus4       = pc_q + 32'd4;
    assign jump_target   = {PCPlus4[31:28], instr_q[25:0], 2'b00};
    assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump has priority: ControlUnit raises Branch alongside Jump for J.
    always_comb begin
        pc_d = PCPlus4;
        if (Jump) begin
            pc_d = jump_target;
        end else if (Branch && Zero) begin
            pc_d = PCPlus4 + branch_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (IMemReady) begin
                        instr_q <= IMemRData;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (Advance) begin
                        pc_q    <= pc_d;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Request is masked during the reset cycle so an abandoned fetch is never seen by memory.
    assign IMemReq    = (state_q == S_REQ) && !reset;
    assign IMemAddr   = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign OPCode     = instr_q[31:26];
    assign Funct      = instr_q[5:0];
    assign InstrValid = (state_q == S_ISSUE);

`ifdef IF_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == S_REQ) && !IMemReady) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; a second instance with RESET_PC at the top
// of the address space covers PC wrap-around.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        IMemReady;
    logic [31:0] IMemRData;
    logic        Advance, Branch, Jump, Zero;

    logic        IMemReq, InstrValid;
    logic [31:0] IMemAddr, Instr, PC, PCPlus4, StallCount;
    logic [5:0]  OPCode, Funct;

    logic        IMemReq2, InstrValid2;
    logic [31:0] IMemAddr2, Instr2, PC2, PCPlus42, StallCount2;
    logic [5:0]  OPCode2, Funct2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .reset(reset),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemRData(IMemRData),
        .Instr(Instr), .OPCode(OPCode), .Funct(Funct), .InstrValid(InstrValid),
        .Advance(Advance), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .PC(PC), .PCPlus4(PCPlus4), .StallCount(StallCount)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemReady(IMemReady), .IMemRData(IMemRData),
        .Instr(Instr2), .OPCode(OPCode2), .Funct(Funct2), .InstrValid(InstrValid2),
        .Advance(Advance), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .PC(PC2), .PCPlus4(PCPlus42), .StallCount(StallCount2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-edge memory response, then the bench stops offering data.
    task automatic fetch(input logic [31:0] word);
        IMemReady = 1'b1;
        IMemRData = word;
        step();
        IMemReady = 1'b0;
        IMemRData = 32'hBAD0_BAD0;
    endtask

    task automatic advance(input logic br, input logic jp, input logic z);
        Advance = 1'b1; Branch = br; Jump = jp; Zero = z;
        step();
        Advance = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", IMemReq); end
        checks++;
        if (PC !== 32'h0 || InstrValid !== 1'b0 || Instr !== 32'h0) begin
            errors++; $display("FAIL reset_state: PC=%h valid=%b instr=%h want 0/0/0", PC, InstrValid, Instr);
        end
        checks++;
        if (OPCode !== 6'h0 || Funct !== 6'h0 || StallCount !== 32'h0) begin
            errors++; $display("FAIL reset_fields: op=%h funct=%h stall=%0d want 0/0/0", OPCode, Funct, StallCount);
        end
        checks++;
        if (PC2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_param: got %h want fffffffc", PC2); end
        reset = 1'b0;
        #1;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
            errors++; $display("FAIL req_after_reset: req=%b addr=%h want 1/0", IMemReq, IMemAddr);
        end
    endtask

    task automatic test_first_fetch();
        fetch(32'h2008_0005);
        checks++;
        if (InstrValid !== 1'b1 || IMemReq !== 1'b0) begin
            errors++; $display("FAIL addi_valid: valid=%b req=%b want 1/0", InstrValid, IMemReq);
        end
        checks++;
        if (OPCode !== 6'h08 || Funct !== 6'h05 || Instr !== 32'h2008_0005) begin
            errors++; $display("FAIL addi_fields: op=%h funct=%h instr=%h want 08/05/20080005", OPCode, Funct, Instr);
        end
        step();
        checks++;
        if (InstrValid !== 1'b1 || PC !== 32'h0) begin
            errors++; $display("FAIL issue_hold: valid=%b PC=%h want 1/0", InstrValid, PC);
        end
        advance(1'b0, 1'b0, 1'b0);
        checks++;
        if (PC !== 32'h4 || IMemReq !== 1'b1 || IMemAddr !== 32'h4 || InstrValid !== 1'b0) begin
            errors++; $display("FAIL addi_advance: PC=%h req=%b addr=%h valid=%b want 4/1/4/0", PC, IMemReq, IMemAddr, InstrValid);
        end
        checks++;
        if (PC2 !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 0", PC2); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        // Advance while a request is outstanding must be ignored.
        Advance = 1'b1; Jump = 1'b1;
        step();
        Advance = 1'b0; Jump = 1'b0;
        checks++;
        if (PC !== 32'h4 || IMemReq !== 1'b1 || InstrValid !== 1'b0) begin
            errors++; $display("FAIL advance_in_req: PC=%h req=%b valid=%b want 4/1/0", PC, IMemReq, InstrValid);
        end
        exp_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0000_0020);
            advance(1'b0, 1'b0, 1'b0);
            exp_addr = exp_addr + 32'h4;
            checks++;
            if (IMemAddr !== exp_addr || IMemReq !== 1'b1) begin
                errors++; $display("FAIL seq_addr%0d: addr=%h req=%b want %h/1", i, IMemAddr, IMemReq, exp_addr);
            end
        end
    endtask

    task automatic test_branch();
        fetch(32'h1000_FFFE);
        checks++;
        if (OPCode !== 6'h04) begin errors++; $display("FAIL beq_opcode: got %h want 04", OPCode); end
        advance(1'b1, 1'b0, 1'b1);
        checks++;
        if (PC !== 32'h0000_000C) begin errors++; $display("FAIL beq_taken: got %h want 0000000c", PC); end
        fetch(32'h0000_0020);
        advance(1'b0, 1'b0, 1'b0);
        fetch(32'h1000_FFFE);
        advance(1'b1, 1'b0, 1'b0);
        checks++;
        if (PC !== 32'h0000_0014) begin errors++; $display("FAIL beq_not_taken: got %h want 00000014", PC); end
    endtask

    task automatic test_jump();
        fetch(32'h0BFF_FFFF);
        advance(1'b0, 1'b1, 1'b0);
        checks++;
        if (PC !== 32'h0FFF_FFFC) begin errors++; $display("FAIL jump_far: got %h want 0ffffffc", PC); end
        fetch(32'h0800_0008);
        advance(1'b0, 1'b1, 1'b0);
        checks++;
        if (PC !== 32'h1000_0020 || PCPlus4 !== 32'h1000_0024) begin
            errors++; $display("FAIL jump_region: PC=%h PCPlus4=%h want 10000020/10000024", PC, PCPlus4);
        end
        fetch(32'h0800_0040);
        advance(1'b1, 1'b1, 1'b1);
        checks++;
        if (PC !== 32'h1000_0100) begin errors++; $display("FAIL jump_over_branch: got %h want 10000100", PC); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_stall;
        reset = 1'b1; IMemReady = 1'b0;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
                errors++; $display("FAIL stall_hold%0d: req=%b addr=%h want 1/0", i, IMemReq, IMemAddr);
            end
            if (i < 5) step();
        end
        fetch(32'h0000_0020);
`ifdef IF_STALL_COUNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        checks++;
        if (StallCount !== exp_stall || InstrValid !== 1'b1) begin
            errors++; $display("FAIL stall_count: got %0d valid=%b want %0d/1", StallCount, InstrValid, exp_stall);
        end
    endtask

    task automatic test_reset_mid();
        advance(1'b0, 1'b0, 1'b0);
        fetch(32'h2008_0005);
        reset = 1'b1; Advance = 1'b1;
        step();
        Advance = 1'b0;
        checks++;
        if (PC !== 32'h0 || InstrValid !== 1'b0 || Instr !== 32'h0 || IMemReq !== 1'b0) begin
            errors++; $display("FAIL reset_in_issue: PC=%h valid=%b instr=%h req=%b want 0/0/0/0", PC, InstrValid, Instr, IMemReq);
        end
        IMemReady = 1'b1; IMemRData = 32'hDEAD_BEEF;
        step();
        checks++;
        if (InstrValid !== 1'b0 || Instr !== 32'h0 || PC !== 32'h0) begin
            errors++; $display("FAIL reset_in_req: valid=%b instr=%h PC=%h want 0/0/0", InstrValid, Instr, PC);
        end
        reset = 1'b0; IMemReady = 1'b0;
        step();
        checks++;
        if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h0 || StallCount !== StallCount2) begin
            errors++; $display("FAIL after_mid_reset: valid=%b req=%b addr=%h want 0/1/0", InstrValid, IMemReq, IMemAddr);
        end
    endtask

    initial begin
        reset = 1'b1; IMemReady = 1'b0; IMemRData = 32'h0;
        Advance = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
